// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with 2-cycle BRAM read tracking and output FIFO
//
// Owns the architectural fetch PC, issues word reads to a 2-cycle-latency
// instruction BRAM, tags each read with its PC in a 2-stage pipe, and
// buffers returned instructions in a small FIFO presented to decode.
//
// Ports:
//   clk_in            - single clock
//   rst_in            - synchronous active-high reset (acts as a redirect to RESET_PC)
//   redirect_valid_in - execute requests a fetch restart
//   redirect_pc_in    - restart PC, bits [1:0] ignored
//   imem_addr_out     - BRAM word address, fetch_pc[AW+1:2]
//   imem_data_in      - BRAM read data, valid 2 cycles after the address
//   inst_out          - instruction at FIFO head (registered)
//   pc_out            - PC of inst_out (registered)
//   valid_out         - FIFO non-empty
//   ready_in          - decode accepts the head this cycle
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 128,
    parameter int          FIFO_DEPTH = 4,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          redirect_valid_in,
    input  logic [31:0]   redirect_pc_in,
    output logic [AW-1:0] imem_addr_out,
    input  logic [31:0]   imem_data_in,
    output logic [31:0]   inst_out,
    output logic [31:0]   pc_out,
    output logic          valid_out,
    input  logic          ready_in
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic          s0_valid, s1_valid;
    logic [31:0]   s0_pc, s1_pc;

    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   inst_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;

    logic [1:0]    inflight;
    logic [CW-1:0] occupancy;
    logic          issue, deq, wr;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count_next;
    logic [31:0]   head_pc, head_inst;

    logic          unused_pc_low;
    assign unused_pc_low = ^redirect_pc_in[1:0];

    assign imem_addr_out = fetch_pc[AW+1:2];
    assign valid_out     = (fifo_count != '0);

    always_comb begin
        inflight   = {1'b0, s0_valid} + {1'b0, s1_valid};
        occupancy  = CW'(inflight) + fifo_count;
        // Credits are taken from registered counts only, so a slot freed by
        // a dequeue this cycle is not reusable until next cycle.
        issue      = !redirect_valid_in && (occupancy < CW'(FIFO_DEPTH));
        deq        = valid_out && ready_in;
        wr         = s1_valid && !redirect_valid_in;
        rd_next    = deq ? rd_ptr + PW'(1) : rd_ptr;
        count_next = fifo_count + CW'(wr) - CW'(deq);
        // Next head: if the FIFO drains to empty this cycle while a write
        // lands, the incoming entry becomes the head and must bypass memory.
        if (wr && (rd_next == wr_ptr)) begin
            head_pc   = s1_pc;
            head_inst = imem_data_in;
        end else begin
            head_pc   = pc_mem[rd_next];
            head_inst = inst_mem[rd_next];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && wr) begin
            pc_mem[wr_ptr]   <= s1_pc;
            inst_mem[wr_ptr] <= imem_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc   <= RESET_PC;
            s0_valid   <= 1'b0;
            s1_valid   <= 1'b0;
            s0_pc      <= '0;
            s1_pc      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pc_out     <= '0;
            inst_out   <= '0;
        end else if (redirect_valid_in) begin
            // Flush: reads already in the BRAM pipe return untagged and are dropped.
            fetch_pc   <= {redirect_pc_in[31:2], 2'b00};
            s0_valid   <= 1'b0;
            s1_valid   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            s0_valid <= issue;
            if (issue) begin
                s0_pc    <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            s1_valid   <= s0_valid;
            s1_pc      <= s0_pc;
            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_next;
            fifo_count <= count_next;
            // Outputs hold their last value while empty.
            if (count_next != '0) begin
                pc_out   <= head_pc;
                inst_out <= head_inst;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        redirect_valid_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic [6:0]  imem_addr_out;
    logic [31:0] imem_data_in;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] bram [128];
    logic [31:0] bram_r1 = 32'h0;
    logic [31:0] bram_r2 = 32'h0;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        bram_r1 <= bram[imem_addr_out];
        bram_r2 <= bram_r1;
    end
    assign imem_data_in = bram_r2;

    fetch_unit dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .redirect_valid_in (redirect_valid_in),
        .redirect_pc_in    (redirect_pc_in),
        .imem_addr_out     (imem_addr_out),
        .imem_data_in      (imem_data_in),
        .inst_out          (inst_out),
        .pc_out            (pc_out),
        .valid_out         (valid_out),
        .ready_in          (ready_in)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with rst_in low).
    task automatic release_reset(input logic rdy);
        rst_in = 1'b1;
        redirect_valid_in = 1'b0;
        ready_in = rdy;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_out); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", inst_out); end
        checks++; if (imem_addr_out !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", imem_addr_out); end
    endtask

    task automatic test_cold_start();
        release_reset(1'b1);
        for (int c = 0; c <= 10; c++) begin
            if (c < 3) begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL cold_valid c%0d got %b want 0", c, valid_out); end
            end else begin
                checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL cold_valid c%0d got %b want 1", c, valid_out); end
                checks++; if (pc_out !== 32'(4 * (c - 3))) begin errors++; $display("FAIL cold_pc c%0d got %h want %h", c, pc_out, 32'(4 * (c - 3))); end
                checks++; if (inst_out !== 32'h1000_0000 + 32'(c - 3)) begin errors++; $display("FAIL cold_inst c%0d got %h want %h", c, inst_out, 32'h1000_0000 + 32'(c - 3)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        release_reset(1'b0);
        for (int c = 0; c <= 14; c++) begin
            if (c >= 4 && c <= 8) begin
                checks++; if (valid_out !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h1000_0000) begin
                    errors++; $display("FAIL bp_hold c%0d got v=%b pc=%h inst=%h want v=1 pc=0 inst=10000000", c, valid_out, pc_out, inst_out);
                end
            end
            if (c == 8) begin
                checks++; if (dut.fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d want 4", dut.fifo_count); end
                checks++; if (imem_addr_out !== 7'd4) begin errors++; $display("FAIL bp_issued addr got %0d want 4", imem_addr_out); end
                ready_in = 1'b1;
            end
            if (c >= 8) begin
                checks++; if (valid_out !== 1'b1 || pc_out !== 32'(4 * (c - 8))) begin
                    errors++; $display("FAIL bp_drain c%0d got v=%b pc=%h want v=1 pc=%h", c, valid_out, pc_out, 32'(4 * (c - 8)));
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        release_reset(1'b1);
        for (int c = 0; c <= 16; c++) begin
            if (c == 10) begin
                checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL redir_pre_valid got %b want 1", valid_out); end
                redirect_valid_in = 1'b1;
                redirect_pc_in = 32'h0000_0040;
            end else begin
                redirect_valid_in = 1'b0;
            end
            if (c >= 11 && c <= 13) begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL redir_flush c%0d got %b want 0", c, valid_out); end
            end
            if (c >= 14) begin
                checks++; if (valid_out !== 1'b1 || pc_out !== 32'h40 + 32'(4 * (c - 14)) || inst_out !== 32'h1000_0010 + 32'(c - 14)) begin
                    errors++; $display("FAIL redir_new c%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", c, valid_out, pc_out, inst_out,
                                       32'h40 + 32'(4 * (c - 14)), 32'h1000_0010 + 32'(c - 14));
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_dequeue();
        logic [31:0] consumed [$];
        logic [31:0] exp_seq [7];
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'h80, 32'h84, 32'h88, 32'h8C};
        release_reset(1'b1);
        for (int c = 0; c <= 12; c++) begin
            if (c == 5) begin
                checks++; if (valid_out !== 1'b1 || pc_out !== 32'h8) begin errors++; $display("FAIL rdq_head got v=%b pc=%h want v=1 pc=8", valid_out, pc_out); end
                redirect_valid_in = 1'b1;
                redirect_pc_in = 32'h0000_0083;
            end else begin
                redirect_valid_in = 1'b0;
            end
            if (c >= 6 && c <= 8) begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rdq_flush c%0d got %b want 0", c, valid_out); end
            end
            if (valid_out && ready_in) consumed.push_back(pc_out);
            tick();
        end
        checks++; if (consumed.size() != 7) begin errors++; $display("FAIL rdq_count got %0d want 7", consumed.size()); end
        for (int i = 0; i < 7 && i < consumed.size(); i++) begin
            checks++; if (consumed[i] !== exp_seq[i]) begin errors++; $display("FAIL rdq_seq[%0d] got %h want %h", i, consumed[i], exp_seq[i]); end
        end
    endtask

    task automatic test_wrap();
        release_reset(1'b1);
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) begin
                redirect_valid_in = 1'b1;
                redirect_pc_in = 32'h0000_01FC;
            end else begin
                redirect_valid_in = 1'b0;
            end
            if (c == 1) begin
                checks++; if (imem_addr_out !== 7'd127) begin errors++; $display("FAIL wrap_addr1 got %0d want 127", imem_addr_out); end
            end
            if (c == 2) begin
                checks++; if (imem_addr_out !== 7'd0) begin errors++; $display("FAIL wrap_addr2 got %0d want 0", imem_addr_out); end
            end
            if (c == 4) begin
                checks++; if (valid_out !== 1'b1 || pc_out !== 32'h1FC || inst_out !== 32'h1000_007F) begin
                    errors++; $display("FAIL wrap_last got v=%b pc=%h inst=%h want v=1 pc=1fc inst=1000007f", valid_out, pc_out, inst_out);
                end
            end
            if (c == 5) begin
                checks++; if (valid_out !== 1'b1 || pc_out !== 32'h200 || inst_out !== 32'h1000_0000) begin
                    errors++; $display("FAIL wrap_alias got v=%b pc=%h inst=%h want v=1 pc=200 inst=10000000", valid_out, pc_out, inst_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_midrun_reset();
        release_reset(1'b0);
        for (int c = 0; c < 5; c++) tick();
        checks++; if (dut.fifo_count !== 3'd3) begin errors++; $display("FAIL mrst_count got %0d want 3", dut.fifo_count); end
        rst_in = 1'b1;
        ready_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) begin
                checks++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || inst_out !== 32'h0) begin
                    errors++; $display("FAIL mrst_clear got v=%b pc=%h inst=%h want 0 0 0", valid_out, pc_out, inst_out);
                end
            end else if (c < 3) begin
                checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mrst_valid c%0d got %b want 0", c, valid_out); end
            end else begin
                checks++; if (valid_out !== 1'b1 || pc_out !== 32'(4 * (c - 3)) || inst_out !== 32'h1000_0000 + 32'(c - 3)) begin
                    errors++; $display("FAIL mrst_seq c%0d got v=%b pc=%h inst=%h want v=1 pc=%h", c, valid_out, pc_out, inst_out, 32'(4 * (c - 3)));
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 128; k++) bram[k] = 32'h1000_0000 + 32'(k);
        test_reset();
        test_cold_start();
        test_backpressure();
        test_redirect();
        test_redirect_dequeue();
        test_wrap();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
